// File: rtl/timestamp_collector.sv
// Consumer of per-microphone timer words: acks each word and groups captures into event records.
// Optional define TSC_DELTA_EN: record slots hold offsets from the event's earliest timestamp.
module timestamp_collector #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WINDOW_CYC = 100000,
    parameter int unsigned TS_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*TS_W-1:0] ts_in,
    input  logic [NUM_CH-1:0]      ts_valid,
    output logic [NUM_CH-1:0]      ts_ack,
    output logic [NUM_CH*TS_W-1:0] rec_ts,
    output logic [NUM_CH-1:0]      rec_mask,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic                   busy
);

    localparam int unsigned      CNT_W    = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYC - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDelta, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [NUM_CH-1:0]      ack_q, ack_d;
    logic [NUM_CH-1:0]      mask_q, mask_d;
    logic [NUM_CH*TS_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]      capt;
    logic                   accepting;
    logic                   close_event;
`ifdef TSC_DELTA_EN
    logic [TS_W-1:0]        earliest;
    logic [TS_W-1:0]        diff;
    logic                   found;
`endif

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        cnt_d     = cnt_q;
        accepting = (state_q == StIdle) || (state_q == StCollect);
        capt      = ts_valid & ~ack_q & {NUM_CH{accepting}};
        // An ack persists while its valid is high, so each valid pulse gets exactly one ack.
        ack_d     = (ack_q & ts_valid) | capt;
        for (int i = 0; i < NUM_CH; i++) begin
            if (capt[i] && !mask_q[i]) begin
                ts_d[i*TS_W +: TS_W] = ts_in[i*TS_W +: TS_W];
            end
        end
        mask_d      = mask_q | capt;
        close_event = (&mask_d) || (cnt_q == CNT_LAST);

`ifdef TSC_DELTA_EN
        // Wrap-aware minimum: a is earlier than b when (a - b) is negative modulo 2^TS_W.
        earliest = '0;
        diff     = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i]) begin
                diff = ts_q[i*TS_W +: TS_W] - earliest;
                if (!found || diff[TS_W-1]) begin
                    earliest = ts_q[i*TS_W +: TS_W];
                end
                found = 1'b1;
            end
        end
`endif

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (|capt) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (close_event) begin
`ifdef TSC_DELTA_EN
                    state_d = StDelta;
`else
                    state_d = StEmit;
`endif
                end
            end
            StDelta: begin
`ifdef TSC_DELTA_EN
                for (int i = 0; i < NUM_CH; i++) begin
                    if (mask_q[i]) begin
                        ts_d[i*TS_W +: TS_W] = ts_q[i*TS_W +: TS_W] - earliest;
                    end
                end
`endif
                state_d = StEmit;
            end
            StEmit: begin
                if (rec_ready) begin
                    state_d = StIdle;
                    mask_d  = '0;
                    ts_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ack_q   <= '0;
            mask_q  <= '0;
            ts_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            mask_q  <= mask_d;
            ts_q    <= ts_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ts_ack    = ack_q;
    assign rec_ts    = ts_q;
    assign rec_mask  = mask_q;
    assign rec_valid = (state_q == StEmit);
    assign busy      = (state_q != StIdle);

endmodule
